// File: rtl/mem_init_loader_pkg.sv
// Shared types and width helpers for the RAM init loader.
package mem_init_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      WRITE  = 3'd2,
      VERIFY = 3'd3,
      CHECK  = 3'd4,
      DONE   = 3'd5,
      FAIL   = 3'd6
   } state_e;

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // The mux reserves two address bits, so the RAM itself sees ADDR_WIDTH-2.
   function automatic int mem_addr_width(input int addr_width);
      return addr_width - 2;
   endfunction

   function automatic int byte_cnt_width(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/mem_init_loader_byte_packer.sv
// Packs an 8-bit valid/ready stream into DATA_WIDTH-bit words, first byte in the LSBs.
module byte_packer
   import mem_init_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid,
   output logic                  last_beat
);

   localparam int BYTES = bytes_per_word(DATA_WIDTH);
   localparam int CW    = byte_cnt_width(BYTES);
   localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

   logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  word_valid_q, word_valid_d;
   logic                  fire;

   // Next byte slot, assembled word and completion pulse.
   always_comb begin
      fire         = accept & in_valid;
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (clear) begin
         byte_cnt_d = '0;
      end else if (fire) begin
         word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
         if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d   = '0;
            word_valid_d = 1'b1;
         end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
         end
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         byte_cnt_q   <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign last_beat  = fire & ~clear & (byte_cnt_q == LAST_BYTE);

endmodule

// File: rtl/mem_init_loader.sv
// Init-side loader for the RAM user/init mux: writes a packed byte stream, reads it back
// and hands the RAM to the user side when the XOR checksums agree.
module mem_init_loader
   import mem_init_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic                                  start,
   input  logic [7:0]                            in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic                                  wr_enable_init,
   output logic [mem_addr_width(ADDR_WIDTH)-1:0] waddr_init,
   output logic [DATA_WIDTH-1:0]                 mem_data_in_init,
   output logic                                  rd_enable_init,
   output logic [mem_addr_width(ADDR_WIDTH)-1:0] raddr_init,
   input  logic [DATA_WIDTH-1:0]                 mem_data_out_init,
   output logic                                  wclk_init,
   output logic                                  rclk_init,
   output logic                                  sel,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error
);

   localparam int MAW = mem_addr_width(ADDR_WIDTH);
   localparam logic [MAW-1:0] LAST_WORD = MAW'(NUM_WORDS - 1);

   state_e                state_q, state_d;
   logic [MAW-1:0]        word_cnt_q, word_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [DATA_WIDTH-1:0] wsum_q, wsum_d, rsum_q, rsum_d;
   logic                  rvalid_q, rvalid_d;
   logic                  in_ready_q, in_ready_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic                  sel_q, sel_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic                  launch;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_valid, last_beat;

   byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (launch),
      .accept     (in_ready_q),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .word       (word),
      .word_valid (word_valid),
      .last_beat  (last_beat)
   );

   // Sequencing, checksum accumulation and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      wsum_d     = wsum_q;
      rvalid_d   = rd_en_q;
      launch     = 1'b0;
      // Read data trails the strobe by one cycle, so rvalid gates the accumulation.
      if (rvalid_q) begin
         rsum_d = rsum_q ^ mem_data_out_init;
      end else begin
         rsum_d = rsum_q;
      end
      case (state_q)
         IDLE, DONE, FAIL: begin
            if (start) begin
               launch     = 1'b1;
               state_d    = LOAD;
               word_cnt_d = '0;
               rd_cnt_d   = '0;
               wsum_d     = '0;
               rsum_d     = '0;
            end else begin
               state_d = state_q;
            end
         end
         LOAD: begin
            if (last_beat) begin
               state_d = WRITE;
            end else begin
               state_d = LOAD;
            end
         end
         WRITE: begin
            if (word_valid) begin
               wsum_d = wsum_q ^ word;
            end else begin
               wsum_d = wsum_q;
            end
            if (word_cnt_q == LAST_WORD) begin
               state_d  = VERIFY;
               rd_cnt_d = '0;
            end else begin
               state_d    = LOAD;
               word_cnt_d = word_cnt_q + 1'b1;
            end
         end
         VERIFY: begin
            if (rd_cnt_q == LAST_WORD) begin
               state_d = CHECK;
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
         end
         CHECK: begin
            if (rsum_d == wsum_q) begin
               state_d = DONE;
            end else begin
               state_d = FAIL;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == LOAD);
      wr_en_d    = (state_d == WRITE);
      rd_en_d    = (state_d == VERIFY);
      sel_d      = (state_d == DONE);
      done_d     = (state_d == DONE);
      error_d    = (state_d == FAIL);
      busy_d     = (state_d == LOAD) | (state_d == WRITE) | (state_d == VERIFY) | (state_d == CHECK);
   end

   // Loader state and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         rd_cnt_q   <= '0;
         wsum_q     <= '0;
         rsum_q     <= '0;
         rvalid_q   <= 1'b0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         sel_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         wsum_q     <= wsum_d;
         rsum_q     <= rsum_d;
         rvalid_q   <= rvalid_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready         = in_ready_q;
   assign wr_enable_init   = wr_en_q;
   assign waddr_init       = word_cnt_q;
   assign mem_data_in_init = word;
   assign rd_enable_init   = rd_en_q;
   assign raddr_init       = rd_cnt_q;
   assign wclk_init        = clk;
   assign rclk_init        = clk;
   // A restart takes the RAM back from the user side within the start cycle.
   assign sel              = sel_q & ~start;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;

endmodule

// File: tb/tb_mem_init_loader.sv
// Randomized bench for mem_init_loader with behavioural RAM and checksum model.
module tb_mem_init_loader;
   localparam int A_DW = 8;
   localparam int A_AW = 8;
   localparam int A_N  = 4;
   localparam int B_DW = 32;
   localparam int B_AW = 3;
   localparam int B_N  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A: 8-bit words, 4 of 64 locations
   logic             a_resetn = 1'b0, a_start = 1'b0, a_in_valid = 1'b0;
   logic [7:0]       a_in_data = 8'h00;
   logic             a_in_ready, a_wr_en, a_rd_en, a_wclk, a_rclk, a_sel, a_busy, a_done, a_error;
   logic [A_AW-3:0]  a_waddr, a_raddr;
   logic [A_DW-1:0]  a_wdata;
   logic [A_DW-1:0]  a_rdata = '0;
   logic [A_DW-1:0]  a_mem [64];
   logic [7:0]       a_bytes [A_N];
   int               a_corrupt = -1;
   int               a_xfer = 0;
   int               a_first_edge = 0, a_end_edge = 0;
   int               a_wlog_addr[$];
   logic [A_DW-1:0]  a_wlog_data[$];
   int               a_wlog_xfer[$];

   mem_init_loader #(.DATA_WIDTH(A_DW), .ADDR_WIDTH(A_AW), .NUM_WORDS(A_N)) u_dut_a (
      .clk(clk), .resetn(a_resetn), .start(a_start), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .wr_enable_init(a_wr_en), .waddr_init(a_waddr),
      .mem_data_in_init(a_wdata), .rd_enable_init(a_rd_en), .raddr_init(a_raddr),
      .mem_data_out_init(a_rdata), .wclk_init(a_wclk), .rclk_init(a_rclk),
      .sel(a_sel), .busy(a_busy), .done(a_done), .error(a_error));

   always @(posedge clk) begin
      if (a_wr_en) begin
         a_mem[a_waddr] <= a_wdata;
         a_wlog_addr.push_back(int'(a_waddr));
         a_wlog_data.push_back(a_wdata);
         a_wlog_xfer.push_back(a_xfer);
      end
      if (a_rd_en) a_rdata <= a_mem[a_raddr] ^ ((int'(a_raddr) == a_corrupt) ? 8'h01 : 8'h00);
   end

   // ---------------- instance B: 32-bit words, full depth of 2
   logic             b_resetn = 1'b0, b_start = 1'b0, b_in_valid = 1'b0;
   logic [7:0]       b_in_data = 8'h00;
   logic             b_in_ready, b_wr_en, b_rd_en, b_wclk, b_rclk, b_sel, b_busy, b_done, b_error;
   logic [B_AW-3:0]  b_waddr, b_raddr;
   logic [B_DW-1:0]  b_wdata;
   logic [B_DW-1:0]  b_rdata = '0;
   logic [B_DW-1:0]  b_mem [2];
   logic [7:0]       b_bytes [4*B_N];
   int               b_nwrites = 0;

   mem_init_loader #(.DATA_WIDTH(B_DW), .ADDR_WIDTH(B_AW), .NUM_WORDS(B_N)) u_dut_b (
      .clk(clk), .resetn(b_resetn), .start(b_start), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .wr_enable_init(b_wr_en), .waddr_init(b_waddr),
      .mem_data_in_init(b_wdata), .rd_enable_init(b_rd_en), .raddr_init(b_raddr),
      .mem_data_out_init(b_rdata), .wclk_init(b_wclk), .rclk_init(b_rclk),
      .sel(b_sel), .busy(b_busy), .done(b_done), .error(b_error));

   always @(posedge clk) begin
      if (b_wr_en) begin
         b_mem[b_waddr] <= b_wdata;
         b_nwrites <= b_nwrites + 1;
      end
      if (b_rd_en) b_rdata <= b_mem[b_raddr];
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic a_pulse_start(input bit expect_load);
      @(negedge clk);
      a_start = 1'b1;
      #1;
      check_val("a_sel_low_with_start", a_sel, 1'b0);
      @(negedge clk);
      a_start = 1'b0;
      check_val("a_in_ready_after_start", a_in_ready, expect_load);
   endtask

   task automatic a_feed(input int gap, input int nbytes);
      int idx = 0;
      int k = 0;
      while (idx < nbytes && k < 400) begin
         @(negedge clk);
         a_in_valid = ((k % gap) == 0);
         a_in_data  = a_bytes[idx];
         if (a_in_valid && a_in_ready) begin
            if (idx == 0) a_first_edge = cyc + 1;
            idx++;
            a_xfer++;
         end
         k++;
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      check_val("a_bytes_accepted", idx, nbytes);
   endtask

   task automatic a_wait_end();
      int k = 0;
      while (!(a_done || a_error) && k < 100) begin
         @(negedge clk);
         k++;
      end
      a_end_edge = cyc;
      check_val("a_reaches_end", a_done | a_error, 1'b1);
   endtask

   task automatic a_run(input int gap, input int corrupt, input bit vstart, input bit lat_chk);
      logic [7:0] wsum_m = 8'h00;
      logic [7:0] rsum_m = 8'h00;
      bit pass_m;
      int k = 0;
      int base = a_wlog_addr.size();
      for (int i = 0; i < A_N; i++) begin
         wsum_m ^= a_bytes[i];
         rsum_m ^= a_bytes[i] ^ ((i == corrupt) ? 8'h01 : 8'h00);
      end
      pass_m    = (wsum_m == rsum_m);
      a_corrupt = corrupt;
      a_xfer    = 0;
      a_pulse_start(1'b1);
      a_feed(gap, A_N);
      if (vstart) begin
         while (!a_rd_en && k < 50) begin
            @(negedge clk);
            k++;
         end
         check_val("a_saw_verify", a_rd_en, 1'b1);
         a_pulse_start(1'b0);
      end
      a_wait_end();
      if (lat_chk) check_val("a_sel_latency", (a_end_edge - a_first_edge) <= 4*2+4+2, 1'b1);
      check_val("a_done", a_done, pass_m);
      check_val("a_error", a_error, !pass_m);
      check_val("a_sel", a_sel, pass_m);
      check_val("a_busy_end", a_busy, 1'b0);
      check_val("a_write_count", a_wlog_addr.size() - base, A_N);
      for (int i = 0; i < A_N && base + i < a_wlog_addr.size(); i++) begin
         check_val("a_write_addr", a_wlog_addr[base+i], i);
         check_val("a_write_data", a_wlog_data[base+i], a_bytes[i]);
         check_val("a_write_after_word", a_wlog_xfer[base+i] >= i + 1, 1'b1);
         check_val("a_mem", a_mem[i], a_bytes[i]);
      end
   endtask

   task automatic b_run();
      logic [31:0] exp_w [B_N];
      int idx = 0;
      int k = 0;
      int n0 = b_nwrites;
      for (int w = 0; w < B_N; w++)
         exp_w[w] = {b_bytes[4*w+3], b_bytes[4*w+2], b_bytes[4*w+1], b_bytes[4*w]};
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      while (idx < 4*B_N && k < 200) begin
         @(negedge clk);
         b_in_valid = 1'b1;
         b_in_data  = b_bytes[idx];
         if (b_in_ready) idx++;
         k++;
      end
      @(negedge clk);
      b_in_valid = 1'b0;
      k = 0;
      while (!(b_done || b_error) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_val("b_done", b_done, 1'b1);
      check_val("b_error", b_error, 1'b0);
      check_val("b_sel", b_sel, 1'b1);
      check_val("b_write_count", b_nwrites - n0, B_N);
      check_val("b_mem0", b_mem[0], exp_w[0]);
      check_val("b_mem1", b_mem[1], exp_w[1]);
   endtask

   task automatic randomize_a();
      for (int i = 0; i < A_N; i++) a_bytes[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      check_val("rst_in_ready", a_in_ready, 1'b0);
      check_val("rst_strobes", {a_wr_en, a_rd_en}, 2'b00);
      check_val("rst_addrs", {a_waddr, a_raddr}, 12'h000);
      check_val("rst_wdata", a_wdata, 8'h00);
      check_val("rst_flags", {a_sel, a_busy, a_done, a_error}, 4'h0);
      check_val("rst_b_flags", {b_in_ready, b_wr_en, b_rd_en, b_sel, b_busy, b_done, b_error}, 7'h00);
      check_val("clk_fwd_low", {a_wclk, a_rclk, b_wclk, b_rclk}, {4{clk}});
      @(posedge clk);
      #1;
      check_val("clk_fwd_high", {a_wclk, a_rclk, b_wclk, b_rclk}, {4{clk}});
      a_resetn = 1'b1;
      b_resetn = 1'b1;
      @(negedge clk);

      a_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      a_run(1, -1, 1'b0, 1'b1);

      for (int i = 0; i < 4*B_N; i++) b_bytes[i] = 8'(i + 1);
      b_run();
      for (int i = 0; i < 4*B_N; i++) b_bytes[i] = 8'($urandom_range(0, 255));
      b_run();

      randomize_a();
      a_run(3, -1, 1'b0, 1'b0);
      randomize_a();
      a_run(1, 2, 1'b0, 1'b0);
      randomize_a();
      a_run(1, -1, 1'b0, 1'b0);

      randomize_a();
      a_corrupt = -1;
      a_pulse_start(1'b1);
      k = a_wlog_addr.size();
      a_feed(1, 3);
      while (a_wlog_addr.size() - k < 3 && cyc < 50000) @(negedge clk);
      check_val("a_three_written", a_wlog_addr.size() - k, 3);
      @(negedge clk);
      a_resetn = 1'b0;
      @(negedge clk);
      a_resetn = 1'b1;
      check_val("a_midrst_flags", {a_sel, a_busy, a_done, a_error}, 4'h0);
      check_val("a_midrst_strobes", {a_in_ready, a_wr_en, a_rd_en}, 3'b000);
      randomize_a();
      a_run(1, -1, 1'b0, 1'b0);

      randomize_a();
      a_run(1, -1, 1'b1, 1'b0);
      randomize_a();
      a_run(2, -1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_init_loader.md
Name: mem_init_loader

Overview:
- Drives the init-side port of the RAM user/init mux.
- Accepts a byte stream over a valid/ready handshake and packs bytes into DATA_WIDTH-bit words.
- Writes NUM_WORDS words to sequential addresses, reads the whole memory back, and compares XOR checksums.
- On a match, hands the RAM to the user side by asserting sel.

Parameters:
- DATA_WIDTH, 8, memory word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 8, mux address parameter; memory address bus is ADDR_WIDTH-2 bits wide.
- NUM_WORDS, 2**(ADDR_WIDTH-2), number of words loaded and verified; range 1..2**(ADDR_WIDTH-2).

Ports:
- clk  in  1  single clock; all logic on rising edge. One clock; reset is synchronous and active-low.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or FAIL.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_enable_init  out  1  RAM write strobe.
- waddr_init  out  ADDR_WIDTH-2  write address.
- mem_data_in_init  out  DATA_WIDTH  write data.
- rd_enable_init  out  1  RAM read strobe.
- raddr_init  out  ADDR_WIDTH-2  read address.
- mem_data_out_init  in  DATA_WIDTH  RAM read data, valid the cycle after rd_enable_init.
- wclk_init, rclk_init  out  1  both driven directly from clk.
- sel  out  1  1 = user side owns the RAM.
- busy  out  1  high in LOAD/WRITE/VERIFY/CHECK.
- done  out  1  high in DONE.
- error  out  1  high in FAIL.

Behaviour:
- Reset: state=IDLE. All outputs 0: in_ready, wr_enable_init, rd_enable_init, addresses, write data, sel, busy, done, error. Byte, word and checksum registers cleared.
- Reset mid-operation: returns to IDLE on the next edge and sel drops to 0. Partially written RAM content is undefined.
- IDLE: waits for start. On start: word_cnt=0, byte_cnt=0, wsum=0, rsum=0, go to LOAD.
- LOAD:
  - in_ready=1; a byte transfers when in_valid & in_ready.
  - Byte k of a word lands in bits [8k+7:8k]; the first byte goes to the LSBs.
  - On the transfer with byte_cnt=BYTES-1: go to WRITE.
  - Stalls with in_valid=0 are allowed indefinitely.
- WRITE (1 cycle):
  - in_ready=0; wr_enable_init=1, waddr_init=word_cnt, mem_data_in_init=packed word.
  - wsum ^= word.
  - If word_cnt=NUM_WORDS-1: go to VERIFY with rd_cnt=0. Else word_cnt++, byte_cnt=0, back to LOAD.
  - Minimum cost is BYTES+1 cycles per word.
- VERIFY:
  - rd_enable_init=1, raddr_init=rd_cnt, one read per cycle, rd_cnt++.
  - A registered valid flag delays the strobe by one cycle. In each cycle the flag is set, rsum ^= mem_data_out_init.
  - After issuing address NUM_WORDS-1: go to CHECK.
- CHECK (1 cycle): capture the final word into rsum, then compare the next cycle.
  - rsum==wsum -> DONE.
  - rsum!=wsum -> FAIL.
- DONE: sel=1, done=1. Write/read strobes stay 0.
- FAIL: sel=0, error=1.
- start in DONE/FAIL: sel=0 in the same cycle, clear flags and counters, enter LOAD.
- start while busy: ignored.
- Address counters are ADDR_WIDTH-2 bits. NUM_WORDS equal to the full depth never wraps before termination.
- NUM_WORDS=1: one WRITE, one read, then compare.

Decomposition:
- Shared package mem_init_pkg:
  - state encoding localparams: IDLE, LOAD, WRITE, VERIFY, CHECK, DONE, FAIL;
  - BYTES derivation;
  - address width function (ADDR_WIDTH-2).
- One natural sub-module: byte_packer. It takes the byte handshake in and emits a word plus word_valid, with byte counter and shift register. The top FSM holds counters and checksums.

Test Plan:
- DATA_WIDTH=8, NUM_WORDS=4, stream 0x11,0x22,0x33,0x44, ideal RAM model -> writes at addr 0..3 with those values; wsum=0x44; DONE; sel=1 within 4*2+4+2 cycles of the first byte.
- DATA_WIDTH=32, NUM_WORDS=2, bytes 0x01..0x08 -> addr0=0x04030201, addr1=0x08070605; done=1.
- RAM model corrupts addr2 on readback (bit0 flipped) -> FAIL, error=1, sel=0; a subsequent start plus a clean reload reaches DONE.
- in_valid toggled on a 1-in-3 pattern -> same memory contents as the ideal-stream case; no write issued before its word is complete.
- resetn=0 held one cycle after 3 of 4 words are written -> next cycle state IDLE, sel=0, all strobes 0; start reloads successfully.
- start pulsed during VERIFY -> ignored, verify completes normally; start in DONE -> sel falls the same cycle, in_ready=1 the next cycle.
